// File: rtl/conv_pool_mc.sv
// conv_pool_mc: multi-lane 3x3 convolution + 2x2 max-pool block engine.
// Reads one 4x4 pixel block per cycle from a sync-read image memory and, per
// kernel lane, writes one pooled PIX_W result per block, 5 cycles after the read.
// Handshake: start is a 1-cycle pulse honoured only while busy=0; there is no
// backpressure, input_re/output_we are single-cycle strobes with no ready.
// Optional feature: define CONV_POOL_MC_PERF_CNT_EN to add a saturating
// 32-bit busy-cycle counter on port cycle_count.
module conv_pool_mc #(
  parameter int NUM_KERNELS = 3,
  parameter int PIX_W       = 8,
  parameter int COEF_W      = 8,
  parameter int ADDR_W      = 16,
  parameter int SHIFT_W     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [ADDR_W:0]                 num_blocks,
  input  logic [NUM_KERNELS*9*COEF_W-1:0] conv_kernel,
  input  logic [SHIFT_W-1:0]              shift,
  input  logic [NUM_KERNELS-1:0]          kernel_en,
  input  logic [16*PIX_W-1:0]             image_4x4,
  output logic                            input_re,
  output logic [ADDR_W-1:0]               input_addr,
  output logic [NUM_KERNELS-1:0]          output_we,
  output logic [ADDR_W-1:0]               output_addr,
  output logic [NUM_KERNELS*PIX_W-1:0]    y,
  output logic                            busy,
  output logic                            done
`ifdef CONV_POOL_MC_PERF_CNT_EN
  ,
  output logic [31:0]                     cycle_count
`endif
);

  localparam int ACC_W  = PIX_W + COEF_W + 5;
  localparam int PROD_W = PIX_W + COEF_W + 1;
  localparam int KERN_W = 9 * COEF_W;
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W:0]                 num_lat, rd_cnt;
  logic [NUM_KERNELS*KERN_W-1:0]   kern_lat;
  logic [SHIFT_W-1:0]              shift_lat;
  logic [NUM_KERNELS-1:0]          en_lat;
  logic [ADDR_W-1:0]               wr_idx;
  logic                            img_v, cap_v, prod_v, sum_v, out_valid;
  logic                            pipe_busy, accept;
  logic [16*PIX_W-1:0]             pix_q;
  logic signed [PROD_W-1:0]        prod_c [NUM_KERNELS][4][9];
  logic signed [PROD_W-1:0]        prod_q [NUM_KERNELS][4][9];
  logic signed [ACC_W-1:0]         sum_c  [NUM_KERNELS][4];
  logic signed [ACC_W-1:0]         sum_q  [NUM_KERNELS][4];
  logic [NUM_KERNELS*PIX_W-1:0]    y_c;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign accept    = (state == S_IDLE) && start;
  assign pipe_busy = input_re | img_v | cap_v | prod_v | sum_v;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: drain ends on the cycle carrying the final write
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (num_blocks == '0) ? S_DONE : S_READ;
      S_READ:  if (rd_cnt == num_lat - CNT_ONE) state_nxt = S_DRAIN;
      S_DRAIN: if (out_valid && !pipe_busy) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Config latch and read address generation (one read per READ cycle)
  always_ff @(posedge clk) begin
    if (rst) begin
      num_lat    <= '0;
      kern_lat   <= '0;
      shift_lat  <= '0;
      en_lat     <= '0;
      rd_cnt     <= '0;
      input_re   <= 1'b0;
      input_addr <= '0;
    end else begin
      input_re <= (state == S_READ);
      if (accept) begin
        num_lat   <= num_blocks;
        kern_lat  <= conv_kernel;
        shift_lat <= shift;
        en_lat    <= kernel_en;
        rd_cnt    <= '0;
      end
      if (state == S_READ) begin
        input_addr <= rd_cnt[ADDR_W-1:0];
        rd_cnt     <= rd_cnt + CNT_ONE;
      end
    end
  end

  // Pipeline valids and registered outputs; writes land in read order
  always_ff @(posedge clk) begin
    if (rst) begin
      img_v       <= 1'b0;
      cap_v       <= 1'b0;
      prod_v      <= 1'b0;
      sum_v       <= 1'b0;
      out_valid   <= 1'b0;
      output_we   <= '0;
      output_addr <= '0;
      y           <= '0;
      wr_idx      <= '0;
    end else begin
      img_v     <= input_re;
      cap_v     <= img_v;
      prod_v    <= cap_v;
      sum_v     <= prod_v;
      out_valid <= sum_v;
      output_we <= sum_v ? en_lat : '0;
      if (accept) wr_idx <= '0;
      if (sum_v) begin
        y           <= y_c;
        output_addr <= wr_idx;
        wr_idx      <= wr_idx + ADR_ONE;
      end
    end
  end

  // Datapath registers: pixel capture, products, window sums
  always_ff @(posedge clk) begin
    if (img_v)  pix_q  <= image_4x4;
    if (cap_v)  prod_q <= prod_c;
    if (prod_v) sum_q  <= sum_c;
  end

  // Unsigned pixel times signed weight for every tap of the four 3x3 windows
  always_comb begin
    logic [PIX_W-1:0]  px;
    logic [COEF_W-1:0] wt;
    px = '0;
    wt = '0;
    for (int k = 0; k < NUM_KERNELS; k++)
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
              px = pix_q[PIX_W*(4*(i+r)+j+c) +: PIX_W];
              wt = kern_lat[k*KERN_W + COEF_W*(3*r+c) +: COEF_W];
              prod_c[k][2*i+j][3*r+c] =
                $signed({{(PROD_W-PIX_W){1'b0}}, px}) *
                $signed({{(PROD_W-COEF_W){wt[COEF_W-1]}}, wt});
            end
  end

  // Nine-term signed accumulation per window
  always_comb begin
    logic signed [ACC_W-1:0] acc;
    acc = '0;
    for (int k = 0; k < NUM_KERNELS; k++)
      for (int o = 0; o < 4; o++) begin
        acc = '0;
        for (int t = 0; t < 9; t++)
          acc = acc + {{(ACC_W-PROD_W){prod_q[k][o][t][PROD_W-1]}}, prod_q[k][o][t]};
        sum_c[k][o] = acc;
      end
  end

  // Requantise (arithmetic shift), clamp to pixel range, then 2x2 max-pool
  always_comb begin
    logic signed [ACC_W-1:0] sh;
    logic [PIX_W-1:0]        cl, best;
    y_c  = '0;
    sh   = '0;
    cl   = '0;
    best = '0;
    for (int k = 0; k < NUM_KERNELS; k++) begin
      best = '0;
      for (int o = 0; o < 4; o++) begin
        sh = sum_q[k][o] >>> shift_lat;
        if (sh[ACC_W-1])       cl = '0;
        else if (sh > PIX_MAX) cl = '1;
        else                   cl = sh[PIX_W-1:0];
        if (cl > best) best = cl;
      end
      y_c[k*PIX_W +: PIX_W] = best;
    end
  end

`ifdef CONV_POOL_MC_PERF_CNT_EN
  // Busy-cycle counter: cleared on accepted start, saturates at all-ones
  always_ff @(posedge clk) begin
    if (rst)                                 cycle_count <= '0;
    else if (accept)                         cycle_count <= '0;
    else if (busy && cycle_count != '1)      cycle_count <= cycle_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_conv_pool_mc.sv
// Testbench for conv_pool_mc: randomized and directed block runs, with a
// reference model computing each pooled result straight from the conv/pool
// arithmetic, an expected-write queue and an independent output monitor.
module tb_conv_pool_mc;

  localparam int NK = 3;
  localparam int PW = 8;
  localparam int CW = 8;
  localparam int AW = 16;
  localparam int SW = 4;
  localparam int KW = 9 * CW;
  localparam int EW = AW + NK*PW + NK;

  // ---------------- clock / reset / DUT ----------------
  logic              clk_tb = 1'b0;
  logic              rst;
  logic              start;
  logic [AW:0]       num_blocks;
  logic [NK*KW-1:0]  conv_kernel;
  logic [SW-1:0]     shift;
  logic [NK-1:0]     kernel_en;
  logic [16*PW-1:0]  image_4x4;
  logic              input_re;
  logic [AW-1:0]     input_addr;
  logic [NK-1:0]     output_we;
  logic [AW-1:0]     output_addr;
  logic [NK*PW-1:0]  y;
  logic              busy;
  logic              done;
`ifdef CONV_POOL_MC_PERF_CNT_EN
  logic [31:0]       cycle_count;
`endif

  always #5 clk_tb = ~clk_tb;

  conv_pool_mc #(
    .NUM_KERNELS(NK), .PIX_W(PW), .COEF_W(CW), .ADDR_W(AW), .SHIFT_W(SW)
  ) dut (
    .clk(clk_tb),
    .rst(rst),
    .start(start),
    .num_blocks(num_blocks),
    .conv_kernel(conv_kernel),
    .shift(shift),
    .kernel_en(kernel_en),
    .image_4x4(image_4x4),
    .input_re(input_re),
    .input_addr(input_addr),
    .output_we(output_we),
    .output_addr(output_addr),
    .y(y),
    .busy(busy),
    .done(done)
`ifdef CONV_POOL_MC_PERF_CNT_EN
    ,
    .cycle_count(cycle_count)
`endif
  );

  // Sync-read image memory
  logic [16*PW-1:0] mem [0:511];
  always @(posedge clk_tb) if (input_re) image_4x4 <= mem[input_addr[8:0]];

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int re_cnt = 0;
  int done_cnt = 0;
  int wr_total = 0;
  int first_re = -1;
  int first_we = -1;
  int lane_cnt [NK];
  logic [EW-1:0] exp_q[$];

  logic [NK*KW-1:0] kern;
  int               shf;
  logic [NK-1:0]    en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [PW-1:0] ref_y(input logic [16*PW-1:0] img,
                                          input logic [KW-1:0] w9, input int sh);
    int best, s;
    logic [7:0] pb;
    logic signed [7:0] wb;
    best = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) begin
            pb = img[PW*(4*(i+r)+j+c) +: PW];
            wb = w9[CW*(3*r+c) +: CW];
            s += int'(pb) * int'(wb);
          end
        s = s >>> sh;
        if (s < 0)    s = 0;
        if (s > 255)  s = 255;
        if (s > best) best = s;
      end
    return PW'(best);
  endfunction

  task automatic push_expect(input int num);
    logic [NK*PW-1:0] yv;
    for (int b = 0; b < num; b++) begin
      yv = '0;
      for (int k = 0; k < NK; k++)
        yv[k*PW +: PW] = ref_y(mem[b], kern[k*KW +: KW], shf);
      exp_q.push_back({AW'(b), yv, en});
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_tb) begin
    logic [EW-1:0] e;
    cyc = cyc + 1;
    if (input_re) begin
      re_cnt++;
      if (first_re < 0) first_re = cyc;
    end
    if (done) done_cnt++;
    if (output_we != '0) begin
      wr_total++;
      if (first_we < 0) first_we = cyc;
      for (int k = 0; k < NK; k++) if (output_we[k]) lane_cnt[k]++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0d we=%b y=%0h", output_addr, output_we, y);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(output_addr), 64'(e[EW-1 -: AW]));
        chk("wr_y",    64'(y),           64'(e[NK +: NK*PW]));
        chk("wr_we",   64'(output_we),   64'(e[NK-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    re_cnt = 0; done_cnt = 0; wr_total = 0; first_re = -1; first_we = -1;
    for (int k = 0; k < NK; k++) lane_cnt[k] = 0;
  endtask

  task automatic fill_rand(input int n);
    for (int b = 0; b < n; b++)
      for (int i = 0; i < 16; i++) mem[b][8*i +: 8] = 8'($urandom);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 16; i++) mem[0][8*i +: 8] = 8'(i);
  endtask

  task automatic kern_all(input logic [7:0] v);
    for (int i = 0; i < NK*9; i++) kern[8*i +: 8] = v;
  endtask

  task automatic kern_rand();
    for (int i = 0; i < NK*9; i++) kern[8*i +: 8] = 8'($urandom);
  endtask

  task automatic issue_start(input int num);
    @(posedge clk_tb); #1;
    start = 1'b1;
    num_blocks = (AW+1)'(num);
    conv_kernel = kern;
    shift = SW'(shf);
    kernel_en = en;
    @(posedge clk_tb); #1;
    // scramble config: a latched design must ignore these
    start = 1'b0;
    num_blocks = (AW+1)'($urandom);
    for (int i = 0; i < NK*9; i++) conv_kernel[8*i +: 8] = 8'($urandom);
    shift = SW'($urandom);
    kernel_en = NK'($urandom);
  endtask

  task automatic run(input int num, input int ext_start);
    int k;
    bit got;
    push_expect(num);
    clear_counts();
    issue_start(num);
    got = 1'b0;
    for (k = 1; k <= num + 40; k++) begin
      @(negedge clk_tb);
      start = (ext_start != 0) && (k == 5);
      if (k == 1) chk("busy_after_start", 64'(busy), 64'(1));
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("done_seen", 64'(got), 64'(1));
    chk("done_cycle", 64'(k), 64'((num == 0) ? 1 : num + 7));
    @(negedge clk_tb);
    chk("busy_after_done", 64'(busy), 64'(0));
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("we_after_done", 64'(output_we), 64'(0));
    chk("done_count", 64'(done_cnt), 64'(1));
    chk("read_count", 64'(re_cnt), 64'(num));
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    for (int l = 0; l < NK; l++)
      chk("lane_writes", 64'(lane_cnt[l]), 64'(en[l] ? num : 0));
    if (num > 0 && en != '0)
      chk("latency", 64'(first_we - first_re), 64'(5));
`ifdef CONV_POOL_MC_PERF_CNT_EN
    chk("cycle_count", 64'(cycle_count), 64'((num == 0) ? 1 : num + 7));
`endif
  endtask

  task automatic run_abort(input int num, input int at_blk);
    push_expect(num);
    clear_counts();
    issue_start(num);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk_tb);
      if (wr_total >= at_blk) break;
    end
    chk("abort_point_reached", 64'(wr_total >= at_blk), 64'(1));
    @(posedge clk_tb); #1;
    rst = 1'b1;
    @(posedge clk_tb); #1;
    rst = 1'b0;
    exp_q.delete();
    done_cnt = 0;
    re_cnt = 0;
    @(negedge clk_tb);
    chk("abort_input_re", 64'(input_re), 64'(0));
    chk("abort_input_addr", 64'(input_addr), 64'(0));
    chk("abort_we", 64'(output_we), 64'(0));
    chk("abort_out_addr", 64'(output_addr), 64'(0));
    chk("abort_y", 64'(y), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    repeat (30) @(negedge clk_tb);
    chk("abort_no_done", 64'(done_cnt), 64'(0));
    chk("abort_no_reads", 64'(re_cnt), 64'(0));
`ifdef CONV_POOL_MC_PERF_CNT_EN
    chk("abort_cycle_count", 64'(cycle_count), 64'(0));
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; num_blocks = '0; conv_kernel = '0;
    shift = '0; kernel_en = '0; image_4x4 = '0;
    kern = '0; shf = 0; en = '0;
    for (int b = 0; b < 512; b++) mem[b] = '0;
    repeat (3) @(posedge clk_tb);
    #1 rst = 1'b0;
    @(negedge clk_tb);
    chk("rst_input_re", 64'(input_re), 64'(0));
    chk("rst_we", 64'(output_we), 64'(0));
    chk("rst_y", 64'(y), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));

    // identity kernel on ramp block: y = max(p5,p6,p9,p10) = 10
    fill_ramp();
    kern = '0;
    for (int k = 0; k < NK; k++) kern[k*KW + 4*CW +: CW] = 8'd1;
    shf = 0; en = 3'b111;
    run(1, 0);
    chk("identity_y", 64'(y), 64'({3{8'd10}}));

    // all-ones kernel, shift 3: sums 45,54,81,90 -> 11
    kern_all(8'd1); shf = 3;
    run(1, 0);
    chk("box_y", 64'(y), 64'({3{8'd11}}));

    // saturation high
    mem[0] = '1; kern_all(8'h7f); shf = 0;
    run(1, 0);
    chk("sat_high_y", 64'(y), 64'({3{8'd255}}));

    // negative weights clamp to 0
    fill_ramp(); kern_all(8'hff); shf = 0;
    run(1, 0);
    chk("sat_low_y", 64'(y), 64'(0));

    // randomized runs
    for (int t = 0; t < 3; t++) begin
      fill_rand(40); kern_rand();
      shf = $urandom_range(0, 12);
      en = NK'($urandom_range(1, 7));
      run($urandom_range(2, 40), 0);
    end

    // long run with a disabled lane and an ignored extra start
    fill_rand(300); kern_rand(); shf = $urandom_range(3, 9); en = 3'b101;
    run(300, 1);

    // zero-length run
    run(0, 0);

    // reset at block 100 of 300, then a clean run
    fill_rand(300); kern_rand(); shf = $urandom_range(2, 8); en = 3'b111;
    run_abort(300, 100);
    kern_rand(); shf = $urandom_range(0, 8); en = 3'b011;
    run(10, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #2000000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
